// File: rtl/gen_pkg.sv
// Shared types for the generator family: sequencing states and the default signed word.
package gen_pkg;

    localparam int WORD_W = 32;

    typedef logic signed [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } gen_state_e;

endpackage

// File: rtl/yield_index_counter.sv
// Nested tuple-index / pass counter; last flags the final tuple of the final pass.
module yield_index_counter #(
    parameter int N_YIELD  = 2,
    parameter int REPEAT_W = 16,
    localparam int IDX_W   = (N_YIELD > 1) ? $clog2(N_YIELD) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                advance,
    input  logic [REPEAT_W-1:0] repeat_n,
    output logic [IDX_W-1:0]    index,
    output logic                last
);

    logic [REPEAT_W-1:0] pass;
    logic                idx_end;
    logic                pass_end;

    assign idx_end  = (index == IDX_W'(N_YIELD - 1));
    assign pass_end = (pass == repeat_n - REPEAT_W'(1));
    assign last     = idx_end && pass_end;

    // Holding on the last transfer keeps pass below repeat_n, so it can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index <= '0;
            pass  <= '0;
        end else if (clear) begin
            index <= '0;
            pass  <= '0;
        end else if (advance && !last) begin
            if (idx_end) begin
                index <= '0;
                pass  <= pass + REPEAT_W'(1);
            end else begin
                index <= index + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/yield_sequencer.sv
// Emits N_YIELD captured tuples per pass, _repeat passes, over a valid/ready stream.
//   state | meaning
//   IDLE  | nothing captured since reset
//   EMIT  | _valid high, _out holds the current tuple
//   DONE  | all passes delivered (or _repeat was 0); _done held until next _start
module yield_sequencer #(
    parameter int WIDTH    = 32,
    parameter int N_OUT    = 2,
    parameter int N_YIELD  = 2,
    parameter int REPEAT_W = 16
) (
    input  logic                           _clock,
    input  logic                           _reset_n,
    input  logic                           _start,
    input  logic [N_YIELD*N_OUT*WIDTH-1:0] _data,
    input  logic [REPEAT_W-1:0]            _repeat,
    input  logic                           _ready,
    output logic                           _valid,
    output logic [N_OUT*WIDTH-1:0]         _out,
    output logic                           _done
);

    import gen_pkg::*;

    localparam int TUPLE_W = N_OUT * WIDTH;
    localparam int DATA_W  = N_YIELD * TUPLE_W;
    localparam int IDX_W   = (N_YIELD > 1) ? $clog2(N_YIELD) : 1;

    gen_state_e          state;
    gen_state_e          state_nxt;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   data_d;
    logic [REPEAT_W-1:0] repeat_q;
    logic [REPEAT_W-1:0] repeat_d;
    logic [TUPLE_W-1:0]  out_q;
    logic [TUPLE_W-1:0]  out_d;
    logic                valid_q;
    logic                valid_d;
    logic                done_q;
    logic                done_d;
    logic                xfer;
    logic                cnt_clear;
    logic                cnt_advance;
    logic                cnt_last;
    logic [IDX_W-1:0]    index;
    logic [IDX_W-1:0]    index_nxt;

    yield_index_counter #(
        .N_YIELD  (N_YIELD),
        .REPEAT_W (REPEAT_W)
    ) u_index_counter (
        .clk      (_clock),
        .rst_n    (_reset_n),
        .clear    (cnt_clear),
        .advance  (cnt_advance),
        .repeat_n (repeat_q),
        .index    (index),
        .last     (cnt_last)
    );

    assign xfer      = valid_q && _ready;
    assign index_nxt = (index == IDX_W'(N_YIELD - 1)) ? '0 : index + IDX_W'(1);

    // _start outranks a same-cycle transfer: the consumer treats it as a flush.
    always_comb begin
        state_nxt   = state;
        data_d      = data_q;
        repeat_d    = repeat_q;
        out_d       = out_q;
        valid_d     = valid_q;
        done_d      = done_q;
        cnt_clear   = 1'b0;
        cnt_advance = 1'b0;

        if (_start) begin
            data_d    = _data;
            repeat_d  = _repeat;
            cnt_clear = 1'b1;
            if (_repeat == '0) begin
                state_nxt = DONE;
                valid_d   = 1'b0;
                done_d    = 1'b1;
            end else begin
                state_nxt = EMIT;
                valid_d   = 1'b1;
                done_d    = 1'b0;
                out_d     = _data[TUPLE_W-1:0];
            end
        end else if (state == EMIT && xfer) begin
            cnt_advance = 1'b1;
            if (cnt_last) begin
                state_nxt = DONE;
                valid_d   = 1'b0;
                done_d    = 1'b1;
            end else begin
                out_d = data_q[int'(index_nxt)*TUPLE_W +: TUPLE_W];
            end
        end
    end

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            data_q   <= '0;
            repeat_q <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            data_q   <= data_d;
            repeat_q <= repeat_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    assign _valid = valid_q;
    assign _out   = out_q;
    assign _done  = done_q;

endmodule

// File: tb/tb_yield_sequencer.sv
// Directed bench for yield_sequencer (default parameters) plus a 3x5x8 sweep instance with random ready.
module tb_yield_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] data;
    logic [15:0]  rpt;
    logic         ready;
    logic         valid;
    logic [63:0]  out;
    logic         done;

    logic         s_start;
    logic [119:0] s_data;
    logic [15:0]  s_rpt;
    logic         s_ready;
    logic         s_valid;
    logic [23:0]  s_out;
    logic         s_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    yield_sequencer dut (
        ._clock   (clk),
        ._reset_n (rst_n),
        ._start   (start),
        ._data    (data),
        ._repeat  (rpt),
        ._ready   (ready),
        ._valid   (valid),
        ._out     (out),
        ._done    (done)
    );

    yield_sequencer #(
        .WIDTH    (8),
        .N_OUT    (3),
        .N_YIELD  (5),
        .REPEAT_W (16)
    ) dut_sweep (
        ._clock   (clk),
        ._reset_n (rst_n),
        ._start   (s_start),
        ._data    (s_data),
        ._repeat  (s_rpt),
        ._ready   (s_ready),
        ._valid   (s_valid),
        ._out     (s_out),
        ._done    (s_done)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] tup(input int w0, input int w1);
        return {w1, w0};
    endfunction

    function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
        return {d, c, b, a};
    endfunction

    function automatic logic [7:0] sb(input int i);
        return 8'(i * 17 + 3);
    endfunction

    task automatic start_seq(input logic [127:0] d, input logic [15:0] r);
        start = 1'b1;
        data  = d;
        rpt   = r;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int exp_n;
        rst_n   = 1'b0;
        start   = 1'b0;
        data    = '0;
        rpt     = '0;
        ready   = 1'b1;
        s_start = 1'b0;
        s_data  = '0;
        s_rpt   = '0;
        s_ready = 1'b0;
        #12;
        check_eq("reset_valid", valid, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_out", out, 0);
        rst_n = 1'b1;
        tick();
        check_eq("idle_valid", valid, 0);

        // basic pass, ready high
        start_seq(pack4(1, 2, 3, 4), 16'd1);
        check_eq("t1_valid0", valid, 1);
        check_eq("t1_done0", done, 0);
        check_eq("t1_out0", out, tup(1, 2));
        tick();
        check_eq("t1_valid1", valid, 1);
        check_eq("t1_out1", out, tup(3, 4));
        tick();
        check_eq("t1_valid_end", valid, 0);
        check_eq("t1_done_end", done, 1);
        check_eq("t1_out_hold", out, tup(3, 4));
        tick();
        check_eq("t1_done_held", done, 1);
        check_eq("t1_valid_held", valid, 0);

        // backpressure on tuple 0
        ready = 1'b0;
        start_seq(pack4(1, 2, 3, 4), 16'd1);
        check_eq("t2_done_clr", done, 0);
        for (int i = 0; i < 3; i++) begin
            check_eq("t2_stall_out", out, tup(1, 2));
            check_eq("t2_stall_valid", valid, 1);
            tick();
        end
        check_eq("t2_stall_out", out, tup(1, 2));
        ready = 1'b1;
        tick();
        check_eq("t2_out1", out, tup(3, 4));
        check_eq("t2_valid1", valid, 1);
        tick();
        check_eq("t2_done", done, 1);
        check_eq("t2_valid_end", valid, 0);

        // three passes of signed data; later _data changes must be ignored
        start_seq(pack4(-5, 7, -9, 11), 16'd3);
        data = pack4(99, 98, 97, 96);
        for (int i = 0; i < 6; i++) begin
            check_eq("t3_valid", valid, 1);
            check_eq("t3_done_low", done, 0);
            check_eq("t3_out", out, (i % 2 == 0) ? tup(-5, 7) : tup(-9, 11));
            tick();
        end
        check_eq("t3_valid_end", valid, 0);
        check_eq("t3_done", done, 1);

        // zero passes
        start_seq(pack4(1, 2, 3, 4), 16'd0);
        check_eq("t4_valid", valid, 0);
        check_eq("t4_done", done, 1);
        tick();
        check_eq("t4_valid_later", valid, 0);

        // restart while emitting tuple 1
        start_seq(pack4(1, 2, 3, 4), 16'd1);
        tick();
        check_eq("t5_old_t1", out, tup(3, 4));
        start_seq(pack4(10, 20, 30, 40), 16'd1);
        check_eq("t5_new_t0", out, tup(10, 20));
        check_eq("t5_valid", valid, 1);
        tick();
        check_eq("t5_new_t1", out, tup(30, 40));
        tick();
        check_eq("t5_done", done, 1);

        // async reset mid-EMIT, between edges
        start_seq(pack4(1, 2, 3, 4), 16'd5);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_valid_rst", valid, 0);
        check_eq("t6_done_rst", done, 0);
        check_eq("t6_out_rst", out, 0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t6_quiet_valid", valid, 0);
            check_eq("t6_quiet_out", out, 0);
        end

        // sweep instance: scoreboard of tuple order under random ready
        for (int i = 0; i < 15; i++) s_data[i*8 +: 8] = sb(i);
        s_rpt   = 16'd2;
        s_ready = 1'b1;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        exp_n   = 0;
        for (int cyc = 0; cyc < 300 && !s_done; cyc++) begin
            s_ready = 1'($urandom_range(0, 1));
            if (s_valid && s_ready) begin
                check_eq("sweep_tuple", s_out,
                         {sb(3*(exp_n%5)+2), sb(3*(exp_n%5)+1), sb(3*(exp_n%5))});
                exp_n++;
            end
            tick();
        end
        check_eq("sweep_count", exp_n, 10);
        check_eq("sweep_done", s_done, 1);
        check_eq("sweep_valid_end", s_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
